// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and record types for the instruction fetch stage.
package if_fetch_stage_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic        epoch;
    } inflight_tag_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_stage_fetch_fifo.sv
// Synchronous FIFO with a single-cycle flush; holds in-flight tags and fetched instructions.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_doPop  = i_pop && (r_count != '0);
    assign w_doPush = i_push && ((r_count != (AW+1)'(DEPTH)) || w_doPop);
    assign o_data   = r_mem[r_rdPtr];
    assign o_count  = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush && !i_flush) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC generation, imem request/response tracking, fetch queue to IF/ID.
// Define IF_MISALIGN_CHECK_EN to trap misaligned redirect targets on exc_misalign_o.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_i,
    input  logic [31:0] br_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        exc_misalign_o
`endif
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [31:0]   r_fetchPc;
    logic [31:0]   r_lastPc;
    logic          r_epoch;
    logic          w_halted;
    logic          w_misalign;
    logic          w_redirect;
    logic          w_grant;
    logic          w_respKeep;
    logic          w_qPop;
    logic [CW-1:0] w_outstanding;
    logic [CW-1:0] w_occupancy;
    inflight_tag_t w_grantTag;
    inflight_tag_t w_respTag;
    fq_entry_t     w_respEntry;
    fq_entry_t     w_head;

    // Stall wins over redirect: the branch operands are not forwarded yet.
    assign w_redirect = br_i && !stall_i;
    assign w_grant    = imem_req_o && imem_gnt_i;

    // Credits cover both in-flight requests and buffered instructions, so a response always finds room.
    assign imem_req_o  = !rst && !w_halted &&
                         (({1'b0, w_outstanding} + {1'b0, w_occupancy}) < (CW+1)'(FQ_DEPTH));
    assign imem_addr_o = r_fetchPc;

    assign w_grantTag  = '{pc: r_fetchPc, epoch: r_epoch};
    assign w_respKeep  = imem_rvalid_i && !w_redirect && (w_respTag.epoch == r_epoch);
    assign w_respEntry = '{pc: w_respTag.pc, inst: imem_rdata_i};

    assign valid_o = (w_occupancy != '0);
    assign w_qPop  = valid_o && !stall_i;
    assign pc_o    = valid_o ? w_head.pc : r_lastPc;
    assign inst_o  = valid_o ? w_head.inst : NOP_INST;

`ifdef IF_MISALIGN_CHECK_EN
    logic r_halted;

    assign w_misalign     = (br_addr_i[1:0] != 2'b00);
    assign w_halted       = r_halted;
    assign exc_misalign_o = r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_halted <= 1'b0;
        else if (w_redirect) r_halted <= w_misalign;
    end
`else
    assign w_misalign = 1'b0;
    assign w_halted   = 1'b0;
`endif

    // A redirect toggles the epoch so that every older request still in flight is recognised as stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetchPc <= RESET_PC;
            r_epoch   <= 1'b0;
            r_lastPc  <= '0;
        end else begin
            r_lastPc <= (w_redirect && w_misalign) ? br_addr_i : pc_o;
            if (w_redirect) begin
                r_fetchPc <= alignWord(br_addr_i);
                r_epoch   <= ~r_epoch;
            end else if (w_grant) begin
                r_fetchPc <= r_fetchPc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(inflight_tag_t)),
        .DEPTH (FQ_DEPTH)
    ) u_inflight (
        .clk     (clk),
        .rst     (rst),
        .i_flush (1'b0),
        .i_push  (w_grant),
        .i_data  (w_grantTag),
        .i_pop   (imem_rvalid_i),
        .o_data  (w_respTag),
        .o_count (w_outstanding)
    );

    fetch_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_redirect),
        .i_push  (w_respKeep),
        .i_data  (w_respEntry),
        .i_pop   (w_qPop),
        .o_data  (w_head),
        .o_count (w_occupancy)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: per-cycle directed table, redirect corner cases
// and a long run with randomized memory timing and stalls.
`timescale 1ns/1ps
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        br_i;
    logic [31:0] br_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
`ifdef IF_MISALIGN_CHECK_EN
    logic        exc_misalign_o;
`endif

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] brAddr;
        logic        expValid;
        logic [31:0] expPc;
        logic        expReq;
        logic [31:0] expAddr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } pend_t;

    vec_t        vecs[$];
    pend_t       pending[$];
    int          checks = 0;
    int          errors = 0;
    int          memCycle = 0;
    bit          memRandom = 1'b0;
    int          pops;
    logic [31:0] expPc;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .br_i          (br_i),
        .br_addr_i     (br_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .exc_misalign_o (exc_misalign_o)
`endif
    );

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0003;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic br, input logic [31:0] addr);
        stall_i   = stall;
        br_i      = br;
        br_addr_i = addr;
    endtask

    task automatic addVec(input logic stall, input logic br, input logic [31:0] brAddr,
                          input logic expValid, input logic [31:0] expPcV,
                          input logic expReq, input logic [31:0] expAddr);
        vecs.push_back('{stall, br, brAddr, expValid, expPcV, expReq, expAddr});
    endtask

    task automatic waitValid(input string name, input logic [31:0] wantPc);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 32'h0);
            if (valid_o) seen = 1'b1;
        end
        checkOutput({name, " seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({name, " pc"}, pc_o, wantPc);
            checkOutput({name, " inst"}, inst_o, memData(wantPc));
        end
    endtask

    // Instruction memory: in-order responses, latency 1 normally, 1..4 with random grants in random mode.
    initial begin
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            memCycle++;
            if (rst) begin
                pending.delete();
                imem_gnt_i    = 1'b0;
                imem_rvalid_i = 1'b0;
            end else begin
                if (pending.size() > 0 && pending[0].ready <= memCycle) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = memData(pending[0].addr);
                    void'(pending.pop_front());
                end else begin
                    imem_rvalid_i = 1'b0;
                    imem_rdata_i  = 32'hDEAD_BEEF;
                end
                imem_gnt_i = memRandom ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (imem_req_o && imem_gnt_i)
                    pending.push_back('{imem_addr_o,
                                        memCycle + (memRandom ? 1 + int'($urandom_range(0, 3)) : 1)});
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: time limit reached, got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);

        //     stall br  brAddr         valid pc             req  addr
        addVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h4);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'h8);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'hC);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h10);
        addVec(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h14);
        addVec(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h18);
        addVec(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'h1C);
        addVec(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'h1C);
        addVec(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'h1C);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        1'b0, 32'h1C);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h1C);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h14,       1'b1, 32'h20);
        addVec(1'b0, 1'b1, 32'h100,      1'b1, 32'h18,       1'b1, 32'h24);
        addVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h18,       1'b1, 32'h100);
        addVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h18,       1'b1, 32'h104);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h100,      1'b1, 32'h108);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h104,      1'b1, 32'h10C);
        addVec(1'b1, 1'b1, 32'h200,      1'b1, 32'h108,      1'b1, 32'h110);
        addVec(1'b1, 1'b1, 32'h200,      1'b1, 32'h108,      1'b1, 32'h114);
        addVec(1'b0, 1'b1, 32'h200,      1'b1, 32'h108,      1'b0, 32'h118);
        addVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h108,      1'b1, 32'h200);
        addVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h108,      1'b1, 32'h204);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h200,      1'b1, 32'h208);
        addVec(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h204,     1'b1, 32'h20C);
        addVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h204,      1'b1, 32'hFFFF_FFF8);
        addVec(1'b0, 1'b0, 32'h0,        1'b0, 32'h204,      1'b1, 32'hFFFF_FFFC);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1, 32'h4);
        addVec(1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'h8);

        repeat (3) @(negedge clk);
        checkOutput("reset req", 32'(imem_req_o), 32'd0);
        checkOutput("reset addr", imem_addr_o, 32'h0);
        checkOutput("reset valid", 32'(valid_o), 32'd0);
        checkOutput("reset pc", pc_o, 32'h0);
        checkOutput("reset inst", inst_o, NOP_INST);
`ifdef IF_MISALIGN_CHECK_EN
        checkOutput("reset exc", 32'(exc_misalign_o), 32'd0);
`endif

        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].stall, vecs[i].br, vecs[i].brAddr);
            checkOutput($sformatf("cycle %0d valid", i + 1), 32'(valid_o), 32'(vecs[i].expValid));
            checkOutput($sformatf("cycle %0d pc", i + 1), pc_o, vecs[i].expPc);
            checkOutput($sformatf("cycle %0d inst", i + 1), inst_o,
                        vecs[i].expValid ? memData(vecs[i].expPc) : NOP_INST);
            checkOutput($sformatf("cycle %0d req", i + 1), 32'(imem_req_o), 32'(vecs[i].expReq));
            checkOutput($sformatf("cycle %0d addr", i + 1), imem_addr_o, vecs[i].expAddr);
        end

`ifdef IF_MISALIGN_CHECK_EN
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h102);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("misalign exc", 32'(exc_misalign_o), 32'd1);
        checkOutput("misalign pc", pc_o, 32'h102);
        checkOutput("misalign valid", 32'(valid_o), 32'd0);
        checkOutput("misalign req", 32'(imem_req_o), 32'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("halted req", 32'(imem_req_o), 32'd0);
            checkOutput("halted exc", 32'(exc_misalign_o), 32'd1);
            checkOutput("halted pc", pc_o, 32'h102);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h200);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("resume exc", 32'(exc_misalign_o), 32'd0);
        checkOutput("resume req", 32'(imem_req_o), 32'd1);
        checkOutput("resume addr", imem_addr_o, 32'h200);
        waitValid("resume", 32'h200);
`else
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h303);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("aligned target req", 32'(imem_req_o), 32'd1);
        checkOutput("aligned target addr", imem_addr_o, 32'h300);
        checkOutput("aligned target valid", 32'(valid_o), 32'd0);
        waitValid("aligned target", 32'h300);
`endif

        memRandom = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 32'h1000);
        expPc = 32'h1000;
        pops  = 0;
        for (int cyc = 0; cyc < 20000 && pops < 1000; cyc++) begin
            @(negedge clk);
            applyStimulus(($urandom_range(0, 3) == 0), 1'b0, 32'h0);
            if (valid_o && !stall_i) begin
                checkOutput($sformatf("random pop %0d pc", pops), pc_o, expPc);
                checkOutput($sformatf("random pop %0d inst", pops), inst_o, memData(expPc));
                expPc += 32'd4;
                pops++;
            end else if (!valid_o) begin
                checkOutput("random idle inst", inst_o, NOP_INST);
            end
        end
        checkOutput("random instruction count", 32'(pops), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
